// File: rtl/vector_sequencer.sv
// Vector command sequencer: accepts one command at a time and steps the element datapath.
// Latency: 1 cycle for vsetvli/unknown/vl=0, 1+vl for elementwise (vload 2), 2+vl for reductions.
// Backpressure: cmd_ready only in IDLE; RESP holds rsp_valid and payload until rsp_ready.
module vector_sequencer #(
  parameter int VLMAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0,
  output logic [4:0]  dp_opcode,
  output logic [4:0]  dp_vd,
  output logic [4:0]  dp_vs1,
  output logic [4:0]  dp_vs2,
  output logic [7:0]  dp_imm,
  output logic [3:0]  dp_elem,
  output logic        dp_elem_valid,
  output logic        dp_wb_en,
  output logic        dp_first,
  input  logic [31:0] dp_result,
  output logic [3:0]  vl
);

  localparam logic [4:0]  OP_VSETVLI = 5'h17;
  localparam logic [4:0]  OP_VLOAD   = 5'h07;
  localparam logic [4:0]  OP_VADDVI  = 5'h15;
  localparam logic [4:0]  OP_VMUL    = 5'h04;
  localparam logic [4:0]  OP_VACC    = 5'h0D;
  localparam logic [4:0]  OP_VBACC   = 5'h1D;
  localparam logic [31:0] VLMAX_W    = 32'(VLMAX);
  localparam logic [3:0]  VLMAX_4    = 4'(VLMAX);

  typedef enum logic [1:0] {IDLE, EXEC, DRAIN, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  vl_q, vl_d;
  logic [4:0]  op_q, op_d, vd_q, vd_d, vs1_q, vs1_d, vs2_q, vs2_d;
  logic [7:0]  imm_q, imm_d;
  logic [3:0]  elem_q, elem_d;
  logic [3:0]  rem_q, rem_d;     // EXEC cycles still to issue, including the current one
  logic        first_q, first_d;
  logic [31:0] rsp_q, rsp_d;
  logic        is_reduce;

  // Upper immediate bits carry no meaning for this sequencer.
  wire unused_in1 = &{1'b0, cmd_payload_inputs_1[31:8]};

  assign is_reduce = (op_q == OP_VACC) || (op_q == OP_VBACC);

  // State and datapath-field registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vl_q    <= '0;
      op_q    <= '0;
      vd_q    <= '0;
      vs1_q   <= '0;
      vs2_q   <= '0;
      imm_q   <= '0;
      elem_q  <= '0;
      rem_q   <= '0;
      first_q <= 1'b0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      vl_q    <= vl_d;
      op_q    <= op_d;
      vd_q    <= vd_d;
      vs1_q   <= vs1_d;
      vs2_q   <= vs2_d;
      imm_q   <= imm_d;
      elem_q  <= elem_d;
      rem_q   <= rem_d;
      first_q <= first_d;
      rsp_q   <= rsp_d;
    end
  end

  // Command decode, element stepping and response capture.
  always_comb begin
    state_d = state_q;
    vl_d    = vl_q;
    op_d    = op_q;
    vd_d    = vd_q;
    vs1_d   = vs1_q;
    vs2_d   = vs2_q;
    imm_d   = imm_q;
    elem_d  = elem_q;
    rem_d   = rem_q;
    first_d = first_q;
    rsp_d   = rsp_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d  = cmd_payload_function_id[9:5];
          vd_d  = cmd_payload_function_id[4:0];
          vs1_d = cmd_payload_inputs_0[4:0];
          vs2_d = cmd_payload_inputs_1[4:0];
          imm_d = cmd_payload_inputs_1[7:0];
          rsp_d = '0;
          case (cmd_payload_function_id[9:5])
            OP_VSETVLI: begin
              vl_d    = (cmd_payload_inputs_0 > VLMAX_W) ? VLMAX_4 : cmd_payload_inputs_0[3:0];
              rsp_d   = {28'd0, vl_d};
              state_d = RESP;
            end
            OP_VLOAD: begin
              elem_d  = cmd_payload_inputs_1[3:0];
              rem_d   = 4'd1;
              first_d = 1'b1;
              state_d = EXEC;
            end
            OP_VADDVI, OP_VMUL, OP_VACC, OP_VBACC: begin
              if (vl_q == 4'd0) begin
                state_d = RESP;
              end else begin
                elem_d  = '0;
                rem_d   = vl_q;
                first_d = 1'b1;
                state_d = EXEC;
              end
            end
            default: state_d = RESP;
          endcase
        end
      end
      EXEC: begin
        first_d = 1'b0;
        rem_d   = rem_q - 4'd1;
        if (rem_q == 4'd1) begin
          state_d = is_reduce ? DRAIN : RESP;
        end else begin
          elem_d = elem_q + 4'd1;
        end
      end
      DRAIN: begin
        rsp_d   = dp_result;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready             = (state_q == IDLE);
  assign rsp_valid             = (state_q == RESP);
  assign rsp_payload_outputs_0 = rsp_q;
  assign dp_opcode             = op_q;
  assign dp_vd                 = vd_q;
  assign dp_vs1                = vs1_q;
  assign dp_vs2                = vs2_q;
  assign dp_imm                = imm_q;
  assign dp_elem               = elem_q;
  assign dp_elem_valid         = (state_q == EXEC);
  assign dp_wb_en              = (state_q == EXEC) && !is_reduce;
  assign dp_first              = (state_q == EXEC) && first_q;
  assign vl                    = vl_q;

endmodule

// File: doc/vector_sequencer.md
VECTOR_SEQUENCER -- requirements
Module: vector_sequencer

Interface
REQ-001 Parameter VLMAX, default 8, meaning maximum vector length in elements; legal range 1..15.
REQ-002 clk  input  1  single clock, all state rising-edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  sequencer can accept a command.
REQ-006 cmd_payload_function_id  input  10  [9:5] opcode, [4:0] destination vector register vd.
REQ-007 cmd_payload_inputs_0  input  32  vs1 in [4:0]; requested vl for vsetvli.
REQ-008 cmd_payload_inputs_1  input  32  vs2 in [4:0]; immediate in [7:0]; vload element in [3:0].
REQ-009 rsp_valid  output  1  response offered.
REQ-010 rsp_ready  input  1  response accepted.
REQ-011 rsp_payload_outputs_0  output  32  response data.
REQ-012 dp_opcode  output  5  latched opcode; dp_vd, dp_vs1, dp_vs2 output 5 each, dp_imm output 8, all latched fields.
REQ-013 dp_elem  output  4  current element index.
REQ-014 dp_elem_valid  output  1  element strobe, one element per cycle.
REQ-015 dp_wb_en  output  1  write dp_elem of vd this cycle.
REQ-016 dp_first  output  1  first element of an operation (clears reduction accumulator).
REQ-017 dp_result  input  32  datapath reduction result, valid in DRAIN.
REQ-018 vl  output  4  current vector length.

Function
REQ-019 Opcodes: 0x17 vsetvli, 0x07 vload, 0x15 vadd.vi, 0x04 vmul, 0x0D vacc, 0x1D vbacc; any other opcode is unknown.
REQ-020 FSM states IDLE, EXEC, DRAIN, RESP; cmd_ready = 1 only in IDLE.
REQ-021 Command accepted when cmd_valid and cmd_ready are high at a rising edge; all payload fields latched into dp_* that edge.
REQ-022 vsetvli: vl <= min(inputs_0, VLMAX), treating inputs_0 as unsigned 32-bit; next state RESP, payload = new vl zero-extended.
REQ-023 vload: next state EXEC for exactly 1 cycle, dp_elem = inputs_1[3:0], dp_wb_en = 1; then RESP, payload 0.
REQ-024 vadd.vi/vmul: EXEC for vl cycles, dp_elem 0..vl-1 ascending, dp_wb_en = 1; then RESP, payload 0.
REQ-025 vacc/vbacc: EXEC for vl cycles, dp_wb_en = 0; then one DRAIN cycle; dp_result sampled at end of DRAIN is the payload; then RESP.
REQ-026 In EXEC: dp_elem_valid = 1; dp_first = 1 only on the first EXEC cycle; outside EXEC, dp_elem_valid, dp_wb_en, dp_first = 0.
REQ-027 vl = 0 with vadd/vmul/vacc/vbacc: no EXEC/DRAIN, straight to RESP, payload 0.
REQ-028 Unknown opcode: straight to RESP, payload 0, vl unchanged, no element strobes.
REQ-029 RESP: rsp_valid = 1, payload held stable until rsp_valid && rsp_ready edge, then IDLE.
REQ-030 A new command is never accepted in the edge that completes a response; earliest acceptance is the following cycle.
REQ-031 Latency from acceptance edge N: vsetvli/unknown/vl=0 rsp_valid at cycle N+1; elementwise at N+1+vl (vload N+2); reduction at N+2+vl.
REQ-032 vl changes only on an accepted vsetvli; an in-flight operation uses vl as latched at its acceptance.

Reset
REQ-033 reset high: state IDLE, vl = 0, dp_* outputs 0, rsp_valid = 0, payload 0, cmd_ready = 1 after reset deasserts.
REQ-034 reset mid-operation aborts immediately; no response is issued for the aborted command.

Verification
REQ-035 vsetvli inputs_0=20, VLMAX=8 -> rsp_valid next cycle, payload 8, vl=8.
REQ-036 vl=4, vmul vd=3 vs1=1 vs2=2 -> 4 EXEC cycles dp_elem 0,1,2,3, dp_wb_en=1, dp_first only at elem 0, rsp payload 0 at N+5.
REQ-037 vl=3, vacc with dp_result=0x55 in DRAIN -> 3 strobes with dp_wb_en=0, DRAIN, payload 0x55 at N+5.
REQ-038 rsp_ready held low 5 cycles in RESP -> rsp_valid and payload stable, cmd_ready=0 throughout, cmd_valid ignored.
REQ-039 vl=0 vadd.vi, then unknown opcode 0x1F -> each responds next cycle with payload 0, no dp_elem_valid.
REQ-040 reset asserted during EXEC of vl=8 vmul at element 2 -> outputs return to reset values asynchronously, vl=0, no rsp_valid.
